modport_fifo: RTL and testbench
===============================

Name: modport_fifo

Overview:
Single-clock synchronous FIFO with parameterised data width and entry count. It buffers words between a producer (wr_en/wr_data) and a consumer (rd_en/rd_data), and reports status through registered empty/full flags. The read path is either registered or fall-through, selected by a parameter. It serves as a generic buffering primitive and is driven and monitored through the team's fifo_if interface (DRIVER/MONITOR modports, 1 ns clocking skew).

Parameters:
WIDTH, 8, data word width in bits (>=1).
DEPTH, 1, number of storage entries (>=1, need not be a power of two).
REGOUT, 1, 1 = registered read data (one-cycle latency); 0 = fall-through (head word visible combinationally).

Ports:
clk  input  1  single clock; all state changes on rising edge.
rst_n  input  1  asynchronous reset, active-high (1 = reset) despite the suffix.
wr_en  input  1  write request.
wr_data  input  WIDTH  write data.
rd_en  input  1  read request.
rd_data  output  WIDTH  read data.
empty  output  1  FIFO holds 0 entries.
full  output  1  FIFO holds DEPTH entries.

Behaviour:
- Reset (rst_n=1, async, no clock needed): wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, rd_data=0. Memory contents are not cleared. All accesses are ignored while reset is asserted.
- Write accepted iff wr_en && !full. Stores wr_data at wr_ptr; wr_ptr then advances and wraps from DEPTH-1 to 0.
- Read accepted iff rd_en && !empty. rd_ptr advances and wraps from DEPTH-1 to 0.
- Rejected operations (write when full, read when empty) change no state, including pointers, flags and rd_data.
- Simultaneous accepted read and write: count unchanged, both pointers advance.
- Full FIFO with wr_en && rd_en: only the read is accepted; there is no write pass-through.
- Empty FIFO with wr_en && rd_en: only the write is accepted.
- empty and full are registered and derived from the next-state count. They are valid in the cycle after the edge that changes them: empty=1 iff count==0, full=1 iff count==DEPTH.
- DEPTH=1: empty and full are always complementary outside reset.
- REGOUT=1: on an accepted read, rd_data <= mem[rd_ptr] at the same edge, so data is valid one cycle after rd_en is sampled. Otherwise rd_data holds its last value.
- REGOUT=0: rd_data = mem[rd_ptr] combinationally while !empty, and 0 while empty. An accepted read pops the word being shown.
- Reset asserted mid-operation: immediate return to reset state; stored data is lost logically.
- Data ordering is strictly first in, first out.

Optional Feature:
Macro FIFO_STATUS_EN.
- Defined: adds three outputs.
  - count, width $clog2(DEPTH+1): registered occupancy, reset to 0.
  - overflow, 1 bit: sticky, sets when wr_en && full is sampled.
  - underflow, 1 bit: sticky, sets when rd_en && empty is sampled.
  - overflow and underflow clear only on reset.
- Not defined: these ports and their logic are absent. Core behaviour is identical in both builds.

Test Plan:
1. Reset check: assert rst_n=1 with no clock edges -> empty=1, full=0, rd_data=0 immediately.
2. Fill and drain: WIDTH=8, DEPTH=4, REGOUT=1; write 0x11, 0x22, 0x33, 0x44 -> full=1 after the 4th edge; read 4 times -> rd_data sequence 0x11, 0x22, 0x33, 0x44, each one cycle after its rd_en; empty=1 at the end.
3. Overflow and underflow rejection:
   - Write 0x55 while full -> ignored; drain still returns 0x11..0x44.
   - Read while empty -> rd_data holds 0x44, pointers unchanged; with FIFO_STATUS_EN, overflow=1 and underflow=1.
4. Simultaneous access: with 2 entries held (0xA0, 0xA1), apply wr_en=1 (0xA2) and rd_en=1 for 3 cycles -> reads return 0xA0, 0xA1, 0xA2; count stays 2; empty=0 and full=0 throughout.
5. Wrap and fall-through: DEPTH=3, REGOUT=0; push/pop 10 words 0x00..0x09 interleaved -> order preserved across wrap; rd_data equals the head word in the same cycle and is 0 when empty.
6. Mid-operation reset: with 3 entries held, pulse rst_n=1 between clock edges -> empty=1 and full=0 instantly; the next write of 0x7E is followed by a read returning 0x7E.

Source files
------------

// File: rtl/modport_fifo.sv
// modport_fifo: single-clock FIFO with registered empty/full and a registered or fall-through read path.
// Define FIFO_STATUS_EN to add the count, overflow and underflow status outputs.
module modport_fifo #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 1,
    parameter int REGOUT = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       empty,
    output logic                       full
`ifdef FIFO_STATUS_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic             wr_accept;
    logic             rd_accept;

    // A full FIFO never passes a write through, even when a read frees a slot in the same cycle.
    assign wr_accept = wr_en && !full_q;
    assign rd_accept = rd_en && !empty_q;

    // NOTE: every variable gets a default before any conditional update so no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_accept) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
        end
        if (rd_accept) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);
        end
        count_d = count_q + CW'(wr_accept) - CW'(rd_accept);
        empty_d = (count_d == '0);
        full_d  = (count_d == FULL_CNT);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
        end
    end

    // NOTE: storage has no reset; a zero count makes stale contents unreachable.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    if (REGOUT != 0) begin : g_regout
        logic [WIDTH-1:0] rd_data_q;

        always_ff @(posedge clk or posedge rst_n) begin
            if (rst_n) begin
                rd_data_q <= '0;
            end else if (rd_accept) begin
                rd_data_q <= mem[rd_ptr_q];
            end
        end

        assign rd_data = rd_data_q;
    end else begin : g_fallthrough
        // Head word is shown directly; an empty FIFO presents zero instead of stale storage.
        assign rd_data = empty_q ? '0 : mem[rd_ptr_q];
    end

    assign empty = empty_q;
    assign full  = full_q;

`ifdef FIFO_STATUS_EN
    logic overflow_q;
    logic underflow_q;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_en && full_q) begin
                overflow_q <= 1'b1;
            end
            if (rd_en && empty_q) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_modport_fifo.sv
// Directed bench for modport_fifo: a DEPTH=4 registered instance and a DEPTH=3 fall-through instance.
module tb_modport_fifo;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       a_wr_en, a_rd_en;
    logic [7:0] a_wr_data, a_rd_data;
    logic       a_empty, a_full;

    logic       b_wr_en, b_rd_en;
    logic [7:0] b_wr_data, b_rd_data;
    logic       b_empty, b_full;

`ifdef FIFO_STATUS_EN
    logic [2:0] a_count;
    logic       a_ovf, a_unf;
    logic [1:0] b_count;
    logic       b_ovf, b_unf;
`endif

    int vectors;
    int miscompares;

    always #5 clk = ~clk;

    modport_fifo #(.WIDTH(8), .DEPTH(4), .REGOUT(1)) u_reg (
        .clk(clk), .rst_n(rst_n),
        .wr_en(a_wr_en), .wr_data(a_wr_data),
        .rd_en(a_rd_en), .rd_data(a_rd_data),
        .empty(a_empty), .full(a_full)
`ifdef FIFO_STATUS_EN
        , .count(a_count), .overflow(a_ovf), .underflow(a_unf)
`endif
    );

    modport_fifo #(.WIDTH(8), .DEPTH(3), .REGOUT(0)) u_ft (
        .clk(clk), .rst_n(rst_n),
        .wr_en(b_wr_en), .wr_data(b_wr_data),
        .rd_en(b_rd_en), .rd_data(b_rd_data),
        .empty(b_empty), .full(b_full)
`ifdef FIFO_STATUS_EN
        , .count(b_count), .overflow(b_ovf), .underflow(b_unf)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        a_wr_en = 1'b0; a_rd_en = 1'b0; a_wr_data = '0;
        b_wr_en = 1'b0; b_rd_en = 1'b0; b_wr_data = '0;
        #1;
        vectors++;
        if ({a_empty, a_full, a_rd_data} !== {1'b1, 1'b0, 8'h00}) begin
            miscompares++;
            $display("FAIL reset_reg: empty/full/rd_data got %b/%b/%h want 1/0/00", a_empty, a_full, a_rd_data);
        end
        vectors++;
        if ({b_empty, b_full, b_rd_data} !== {1'b1, 1'b0, 8'h00}) begin
            miscompares++;
            $display("FAIL reset_ft: empty/full/rd_data got %b/%b/%h want 1/0/00", b_empty, b_full, b_rd_data);
        end
        #1 rst_n = 1'b0;
        tick();
    endtask

    task automatic test_fill_overflow_drain();
        logic [7:0] fill [4];
        fill[0] = 8'h11; fill[1] = 8'h22; fill[2] = 8'h33; fill[3] = 8'h44;
        for (int i = 0; i < 4; i++) begin
            a_wr_en = 1'b1; a_wr_data = fill[i];
            tick();
            vectors++;
            if ({a_empty, a_full} !== {1'b0, (i == 3)}) begin
                miscompares++;
                $display("FAIL fill_%0d: empty/full got %b/%b want 0/%b", i, a_empty, a_full, (i == 3));
            end
        end
        a_wr_data = 8'h55;
        tick();
        a_wr_en = 1'b0;
        vectors++;
        if ({a_empty, a_full} !== 2'b01) begin
            miscompares++;
            $display("FAIL write_when_full: empty/full got %b/%b want 0/1", a_empty, a_full);
        end
        for (int i = 0; i < 4; i++) begin
            a_rd_en = 1'b1;
            tick();
            vectors++;
            if ({a_rd_data, a_empty, a_full} !== {fill[i], (i == 3), 1'b0}) begin
                miscompares++;
                $display("FAIL drain_%0d: rd_data/empty/full got %h/%b/%b want %h/%b/0",
                         i, a_rd_data, a_empty, a_full, fill[i], (i == 3));
            end
        end
        a_rd_en = 1'b0;
    endtask

    task automatic test_underflow();
        a_rd_en = 1'b1;
        tick();
        a_rd_en = 1'b0;
        vectors++;
        if ({a_rd_data, a_empty, a_full} !== {8'h44, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL read_when_empty: rd_data/empty/full got %h/%b/%b want 44/1/0", a_rd_data, a_empty, a_full);
        end
`ifdef FIFO_STATUS_EN
        vectors++;
        if ({a_ovf, a_unf, a_count} !== {1'b1, 1'b1, 3'd0}) begin
            miscompares++;
            $display("FAIL sticky_flags: ovf/unf/count got %b/%b/%0d want 1/1/0", a_ovf, a_unf, a_count);
        end
`endif
    endtask

    task automatic test_back_to_back();
        logic [7:0] rd_exp [5];
        rd_exp[0] = 8'hA0; rd_exp[1] = 8'hA1; rd_exp[2] = 8'hA2; rd_exp[3] = 8'hA3; rd_exp[4] = 8'hA4;
        a_wr_en = 1'b1;
        a_wr_data = 8'hA0; tick();
        a_wr_data = 8'hA1; tick();
        a_rd_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_wr_data = 8'hA2 + 8'(i);
            tick();
            vectors++;
            if ({a_rd_data, a_empty, a_full} !== {rd_exp[i], 1'b0, 1'b0}) begin
                miscompares++;
                $display("FAIL simul_%0d: rd_data/empty/full got %h/%b/%b want %h/0/0",
                         i, a_rd_data, a_empty, a_full, rd_exp[i]);
            end
`ifdef FIFO_STATUS_EN
            vectors++;
            if (a_count !== 3'd2) begin
                miscompares++;
                $display("FAIL simul_count_%0d: got %0d want 2", i, a_count);
            end
`endif
        end
        a_wr_en = 1'b0;
        for (int i = 3; i < 5; i++) begin
            tick();
            vectors++;
            if ({a_rd_data, a_empty} !== {rd_exp[i], (i == 4)}) begin
                miscompares++;
                $display("FAIL simul_drain_%0d: rd_data/empty got %h/%b want %h/%b",
                         i, a_rd_data, a_empty, rd_exp[i], (i == 4));
            end
        end
        a_rd_en = 1'b0;
    endtask

    task automatic test_wrap_fallthrough();
        // op bit0 = write, bit1 = read; pushes 0x00..0x09 with interleaved pops across several wraps
        logic [1:0] ops [22];
        logic [7:0] model [$];
        logic [7:0] next_word;
        logic [7:0] head_exp;
        logic       wr_ok, rd_ok;
        ops = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11, 2'b01, 2'b11,
                2'b10, 2'b01, 2'b01, 2'b10, 2'b11, 2'b10, 2'b10, 2'b10, 2'b10, 2'b11, 2'b00};
        next_word = 8'h00;
        for (int i = 0; i < 22; i++) begin
            head_exp = (model.size() != 0) ? model[0] : 8'h00;
            vectors++;
            if ({b_rd_data, b_empty, b_full} !== {head_exp, (model.size() == 0), (model.size() == 3)}) begin
                miscompares++;
                $display("FAIL wrap_step_%0d: rd_data/empty/full got %h/%b/%b want %h/%b/%b",
                         i, b_rd_data, b_empty, b_full, head_exp, (model.size() == 0), (model.size() == 3));
            end
            wr_ok = ops[i][0] && (model.size() < 3) && (next_word < 8'd10);
            rd_ok = ops[i][1] && (model.size() != 0);
            b_wr_en = wr_ok;
            b_wr_data = next_word;
            b_rd_en = ops[i][1];
            tick();
            if (rd_ok) void'(model.pop_front());
            if (wr_ok) begin
                model.push_back(next_word);
                next_word++;
            end
        end
        b_wr_en = 1'b0; b_rd_en = 1'b0;
        vectors++;
        if (next_word !== 8'd10 || model.size() != 0 || b_empty !== 1'b1 || b_rd_data !== 8'h00) begin
            miscompares++;
            $display("FAIL wrap_end: pushed %0d left %0d empty %b rd_data %h want 10/0/1/00",
                     next_word, model.size(), b_empty, b_rd_data);
        end
    endtask

    task automatic test_mid_reset();
        a_wr_en = 1'b1;
        a_wr_data = 8'hB0; tick();
        a_wr_data = 8'hB1; tick();
        a_wr_data = 8'hB2; tick();
        a_wr_en = 1'b0;
        rst_n = 1'b1;
        #1;
        vectors++;
        if ({a_empty, a_full, a_rd_data} !== {1'b1, 1'b0, 8'h00}) begin
            miscompares++;
            $display("FAIL mid_reset: empty/full/rd_data got %b/%b/%h want 1/0/00", a_empty, a_full, a_rd_data);
        end
`ifdef FIFO_STATUS_EN
        vectors++;
        if ({a_ovf, a_unf, a_count} !== {1'b0, 1'b0, 3'd0}) begin
            miscompares++;
            $display("FAIL mid_reset_status: ovf/unf/count got %b/%b/%0d want 0/0/0", a_ovf, a_unf, a_count);
        end
`endif
        #1 rst_n = 1'b0;
        tick();
        a_wr_en = 1'b1; a_wr_data = 8'h7E;
        tick();
        a_wr_en = 1'b0; a_rd_en = 1'b1;
        tick();
        a_rd_en = 1'b0;
        vectors++;
        if ({a_rd_data, a_empty, a_full} !== {8'h7E, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL post_reset_rw: rd_data/empty/full got %h/%b/%b want 7e/1/0", a_rd_data, a_empty, a_full);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_fill_overflow_drain();
        test_underflow();
        test_back_to_back();
        test_wrap_fallthrough();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
